// File: rtl/lane_block_track.sv
// Per-lane tracker for falling note blocks: spawns on chart beats, moves blocks down, retires misses.
// Optional hit judging is compiled in with `define LANE_HIT_JUDGE_EN.
module lane_block_track #(
   parameter int SLOTS    = 4,
   parameter int H_TOP    = 120,
   parameter int H_BOTTOM = 720,
   parameter int STEP     = 1,
   parameter int HIT_LO   = 600
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  stop_or_endgame,
   input  logic [6:0]            beat_cnt,
   input  logic                  spawn_en,
   input  logic                  hit,
   output logic [SLOTS*10-1:0]   block_h,
   output logic [SLOTS-1:0]      block_vld,
   output logic                  hit_ok,
   output logic                  hit_bad,
   output logic                  miss,
   output logic                  overflow
);

   localparam logic [9:0]  H_TOP_V    = 10'(H_TOP);
   localparam logic [9:0]  H_BOTTOM_V = 10'(H_BOTTOM);
   localparam logic [9:0]  HIT_LO_V   = 10'(HIT_LO);
   localparam logic [10:0] H_BOTTOM_W = 11'(H_BOTTOM);
   localparam logic [10:0] STEP_W     = 11'(STEP);

`ifdef LANE_HIT_JUDGE_EN
   localparam bit JUDGE_EN = 1'b1;
`else
   localparam bit JUDGE_EN = 1'b0;
`endif

   logic [6:0]       pre_beat_reg;
   logic [9:0]       h_reg [SLOTS];
   logic [SLOTS-1:0] vld_reg;
   logic             hit_ok_reg, hit_bad_reg, miss_reg, overflow_reg;

   logic             clr;
   logic             run;
   logic             beat_add;
   logic             spawn_req;
   logic             any_free;
   logic             hit_act;
   logic             win_found;
   logic [9:0]       best_h;
   logic [SLOTS-1:0] in_win;
   logic [SLOTS-1:0] best_sel;
   logic [SLOTS-1:0] hit_sel;
   logic [SLOTS-1:0] spawn_sel;
   logic [SLOTS-1:0] retire;

   assign clr       = rst | restart;
   assign run       = ~stop_or_endgame;
   assign beat_add  = (beat_cnt != pre_beat_reg);
   assign spawn_req = beat_add & spawn_en & run;
   assign hit_act   = JUDGE_EN & hit & run;

   // Pick the in-window block closest to the bottom; strict '>' keeps the lowest index on a tie.
   always_comb begin
      win_found = 1'b0;
      best_h    = '0;
      best_sel  = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (in_win[i] && (!win_found || h_reg[i] > best_h)) begin
            win_found   = 1'b1;
            best_h      = h_reg[i];
            best_sel    = '0;
            best_sel[i] = 1'b1;
         end
      end
   end

   assign hit_sel = hit_act ? best_sel : '0;

   // Allocation looks only at occupancy from the start of the cycle, so a slot freed now waits a cycle.
   always_comb begin
      any_free  = 1'b0;
      spawn_sel = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!vld_reg[i] && !any_free) begin
            any_free     = 1'b1;
            spawn_sel[i] = spawn_req;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         logic [10:0] sum;

         assign sum         = {1'b0, h_reg[gi]} + STEP_W;
         assign in_win[gi]  = vld_reg[gi] && (h_reg[gi] >= HIT_LO_V) && (h_reg[gi] < H_BOTTOM_V);
         assign retire[gi]  = run && vld_reg[gi] && !hit_sel[gi] && (sum >= H_BOTTOM_W);
         assign block_h[10*gi +: 10] = h_reg[gi];

         always_ff @(posedge clk) begin
            if (clr) begin
               vld_reg[gi] <= 1'b0;
               h_reg[gi]   <= H_BOTTOM_V;
            end else if (run) begin
               if (hit_sel[gi]) begin
                  vld_reg[gi] <= 1'b0;
                  h_reg[gi]   <= H_BOTTOM_V;
               end else if (vld_reg[gi]) begin
                  if (sum >= H_BOTTOM_W) begin
                     vld_reg[gi] <= 1'b0;
                     h_reg[gi]   <= H_BOTTOM_V;
                  end else begin
                     h_reg[gi] <= sum[9:0];
                  end
               end else if (spawn_sel[gi]) begin
                  vld_reg[gi] <= 1'b1;
                  h_reg[gi]   <= H_TOP_V;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (clr) begin
         pre_beat_reg <= '0;
         hit_ok_reg   <= 1'b0;
         hit_bad_reg  <= 1'b0;
         miss_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         pre_beat_reg <= beat_cnt;
         hit_ok_reg   <= hit_act & win_found;
         hit_bad_reg  <= hit_act & ~win_found;
         miss_reg     <= |retire;
         overflow_reg <= spawn_req & ~any_free;
      end
   end

   assign block_vld = vld_reg;
   assign hit_ok    = hit_ok_reg;
   assign hit_bad   = hit_bad_reg;
   assign miss      = miss_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_lane_block_track.sv
// Directed bench for lane_block_track: spawn/move/retire, overflow, hit judging, freeze and restart.
module tb_lane_block_track;

   localparam int SLOTS = 4;
`ifdef LANE_HIT_JUDGE_EN
   localparam bit JUDGE = 1'b1;
`else
   localparam bit JUDGE = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, restart, stop_or_endgame, spawn_en, hit;
   logic [6:0]          beat_cnt;
   logic [SLOTS*10-1:0] block_h;
   logic [SLOTS-1:0]    block_vld;
   logic                hit_ok, hit_bad, miss, overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int misses;

   always #5 clk = ~clk;

   lane_block_track dut (
      .clk             (clk),
      .rst             (rst),
      .restart         (restart),
      .stop_or_endgame (stop_or_endgame),
      .beat_cnt        (beat_cnt),
      .spawn_en        (spawn_en),
      .hit             (hit),
      .block_h         (block_h),
      .block_vld       (block_vld),
      .hit_ok          (hit_ok),
      .hit_bad         (hit_bad),
      .miss            (miss),
      .overflow        (overflow)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] hs(input int i);
      return block_h[10*i +: 10];
   endfunction

   function automatic logic [39:0] hv(input logic [9:0] h3, h2, h1, h0);
      return {h3, h2, h1, h0};
   endfunction

   initial begin
      rst = 1'b1; restart = 1'b0; stop_or_endgame = 1'b0;
      spawn_en = 1'b0; hit = 1'b0; beat_cnt = 7'd0;
      tick();
      tick();
      check_eq("rst_vld", 64'(block_vld), 64'd0);
      check_eq("rst_h", 64'(block_h), 64'(hv(720, 720, 720, 720)));
      check_eq("rst_pulses", 64'({hit_ok, hit_bad, miss, overflow}), 64'd0);
      rst = 1'b0;

      // single block from spawn to miss
      beat_cnt = 7'd3; spawn_en = 1'b1;
      tick();
      spawn_en = 1'b0;
      check_eq("t1_spawn_vld", 64'(block_vld), 64'b0001);
      check_eq("t1_spawn_h", 64'(hs(0)), 64'd120);
      misses = 0;
      repeat (599) begin
         tick();
         misses += int'(miss);
      end
      check_eq("t1_h719", 64'(hs(0)), 64'd719);
      check_eq("t1_vld719", 64'(block_vld), 64'b0001);
      check_eq("t1_no_early_miss", 64'(misses), 64'd0);
      tick();
      check_eq("t1_ret_h", 64'(hs(0)), 64'd720);
      check_eq("t1_ret_vld", 64'(block_vld), 64'd0);
      check_eq("t1_miss", 64'(miss), 64'd1);
      tick();
      check_eq("t1_miss_1cyc", 64'(miss), 64'd0);

      // five spawn beats back to back
      for (int k = 0; k < 5; k++) begin
         beat_cnt = 7'(4 + k); spawn_en = 1'b1;
         tick();
         check_eq("t2_ovf", 64'(overflow), 64'(k == 4));
      end
      spawn_en = 1'b0;
      check_eq("t2_vld", 64'(block_vld), 64'b1111);
      check_eq("t2_h", 64'(block_h), 64'(hv(121, 122, 123, 124)));
      tick();
      check_eq("t2_ovf_1cyc", 64'(overflow), 64'd0);
      check_eq("t2_vld_after", 64'(block_vld), 64'b1111);

      // two blocks in the window, hit takes the lower one
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      beat_cnt = 7'd9; spawn_en = 1'b1;
      tick();
      spawn_en = 1'b0;
      repeat (39) tick();
      beat_cnt = 7'd10; spawn_en = 1'b1;
      tick();
      spawn_en = 1'b0;
      check_eq("t3_h", 64'(block_h), 64'(hv(720, 720, 120, 160)));
      repeat (490) tick();
      check_eq("t3_pre_hit_h", 64'(block_h), 64'(hv(720, 720, 610, 650)));
      hit = 1'b1;
      tick();
      hit = 1'b0;
      check_eq("t3_hit_vld", 64'(block_vld), JUDGE ? 64'b0010 : 64'b0011);
      check_eq("t3_hit_h0", 64'(hs(0)), JUDGE ? 64'd720 : 64'd651);
      check_eq("t3_hit_h1", 64'(hs(1)), 64'd611);
      check_eq("t3_hit_ok", 64'(hit_ok), 64'(JUDGE));
      check_eq("t3_hit_bad", 64'(hit_bad), 64'd0);
      tick();
      check_eq("t3_hit_ok_1cyc", 64'(hit_ok), 64'd0);

      // restart, then a hit with nothing in the window
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check_eq("t3b_rs_vld", 64'(block_vld), 64'd0);
      check_eq("t3b_rs_h", 64'(block_h), 64'(hv(720, 720, 720, 720)));
      check_eq("t3b_rs_miss", 64'(miss), 64'd0);
      beat_cnt = 7'd11; spawn_en = 1'b1;
      tick();
      spawn_en = 1'b0;
      repeat (470) tick();
      check_eq("t3b_h590", 64'(hs(0)), 64'd590);
      hit = 1'b1;
      tick();
      hit = 1'b0;
      check_eq("t3b_hit_bad", 64'(hit_bad), 64'(JUDGE));
      check_eq("t3b_hit_ok", 64'(hit_ok), 64'd0);
      check_eq("t3b_h", 64'(hs(0)), 64'd591);
      check_eq("t3b_vld", 64'(block_vld), 64'b0001);
      tick();
      check_eq("t3b_bad_1cyc", 64'(hit_bad), 64'd0);
      check_eq("t3b_h592", 64'(hs(0)), 64'd592);

      // freeze with beat changes and hits
      stop_or_endgame = 1'b1;
      for (int k = 0; k < 20; k++) begin
         beat_cnt = 7'(12 + k); spawn_en = 1'b1; hit = (k % 3 == 0);
         tick();
         check_eq("t4_frozen", 64'({block_vld, hs(0), hit_ok, hit_bad, miss, overflow}),
                  64'({4'b0001, 10'd592, 4'b0000}));
      end
      stop_or_endgame = 1'b0; spawn_en = 1'b0; hit = 1'b0;
      tick();
      check_eq("t4_resume_h", 64'(hs(0)), 64'd593);
      check_eq("t4_resume_vld", 64'(block_vld), 64'b0001);

      // retire and spawn in the same cycle, then restart mid-flight
      misses = 0;
      repeat (126) begin
         tick();
         misses += int'(miss);
      end
      check_eq("t5_h719", 64'(hs(0)), 64'd719);
      check_eq("t5_no_early_miss", 64'(misses), 64'd0);
      beat_cnt = 7'd32; spawn_en = 1'b1;
      tick();
      spawn_en = 1'b0;
      check_eq("t5_vld", 64'(block_vld), 64'b0010);
      check_eq("t5_h", 64'(block_h), 64'(hv(720, 720, 120, 720)));
      check_eq("t5_miss", 64'(miss), 64'd1);
      check_eq("t5_ovf", 64'(overflow), 64'd0);
      repeat (11) tick();
      check_eq("t5_h131", 64'(hs(1)), 64'd131);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check_eq("t5_rs_vld", 64'(block_vld), 64'd0);
      check_eq("t5_rs_h", 64'(block_h), 64'(hv(720, 720, 720, 720)));
      check_eq("t5_rs_miss", 64'(miss), 64'd0);
      tick();
      check_eq("t5_post_miss", 64'(miss), 64'd0);
      check_eq("t5_post_vld", 64'(block_vld), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
